// File: rtl/next_pc_sequencer_pkg.sv
// Shared fetch-unit types: sequencer states, default reset vector/init length and the
// branch-recovery request record.
package FetchUnitTypes;

  localparam int PC_WIDTH_DEF = 32;
  localparam int HIST_WIDTH_DEF = 10;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_1000;
  localparam int INIT_CYCLES_DEF = 512;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } NextPcSeqState;

  typedef struct packed {
    logic                      valid;
    logic [PC_WIDTH_DEF-1:0]   target;
    logic [HIST_WIDTH_DEF-1:0] history;
  } BranchRecoveryReq;

endpackage

// File: rtl/next_pc_recovery_select.sv
// Combinational picker over the branch-result lanes: the lowest-index lane carrying a
// valid mispredict is the oldest branch and wins.
module next_pc_recovery_select #(
  parameter int ISSUE_WIDTH = 2,
  parameter int PC_WIDTH    = 32,
  parameter int HIST_WIDTH  = 10
) (
  input  logic [ISSUE_WIDTH-1:0]            brValid,
  input  logic [ISSUE_WIDTH-1:0]            brMispred,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]   brTarget,
  input  logic [ISSUE_WIDTH*HIST_WIDTH-1:0] brHistory,
  output logic                              recValid,
  output logic [PC_WIDTH-1:0]               recTarget,
  output logic [HIST_WIDTH-1:0]             recHistory
);

  // Scan from the youngest lane down so the lowest index is the last to overwrite.
  always_comb begin
    recValid   = 1'b0;
    recTarget  = '0;
    recHistory = '0;
    for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
      if (brValid[i] && brMispred[i]) begin
        recValid   = 1'b1;
        recTarget  = brTarget[i*PC_WIDTH +: PC_WIDTH];
        recHistory = brHistory[i*HIST_WIDTH +: HIST_WIDTH];
      end
    end
  end

endmodule

// File: rtl/next_pc_sequencer.sv
// Next-PC source selection with table-init hold-off and post-redirect bubbles.
// The interrupt source and its pending register exist only with NEXT_PC_SEQ_INTERRUPT_EN.
//   state  | meaning
//   INIT   | predictor/BTB tables initializing, fetch idle
//   RUN    | normal fetch, PC follows the predictor
//   BUBBLE | fetch invalid for a fixed window after a redirect
module next_pc_sequencer
  import FetchUnitTypes::*;
#(
  parameter int                   PC_WIDTH         = PC_WIDTH_DEF,
  parameter int                   ISSUE_WIDTH      = 2,
  parameter int                   HIST_WIDTH       = HIST_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR     = PC_WIDTH'(RESET_VECTOR_DEF),
  parameter int                   INIT_CYCLES      = INIT_CYCLES_DEF,
  parameter int                   REDIRECT_BUBBLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall,
  input  logic [PC_WIDTH-1:0]               predNextPC,
  input  logic [ISSUE_WIDTH-1:0]            brValid,
  input  logic [ISSUE_WIDTH-1:0]            brMispred,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]   brTarget,
  input  logic [ISSUE_WIDTH*HIST_WIDTH-1:0] brHistory,
  input  logic                              interruptAddrWE,
  input  logic [PC_WIDTH-1:0]               interruptAddrIn,
  input  logic [PC_WIDTH-1:0]               pcOut,
  output logic                              pcWE,
  output logic [PC_WIDTH-1:0]               pcIn,
  output logic                              fetchValid,
  output logic                              initBusy,
  output logic                              recoverBrHistory,
  output logic [HIST_WIDTH-1:0]             recoveredBrHistory
);

  // One counter serves both the init wait and the bubble window.
  localparam int CNT_MAX = (INIT_CYCLES > 8) ? INIT_CYCLES : 8;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUB_LOAD  = CNT_W'(REDIRECT_BUBBLES);
  localparam NextPcSeqState REDIRECT_STATE = (REDIRECT_BUBBLES == 0) ? RUN : BUBBLE;

  NextPcSeqState             state, stateNext;
  logic [CNT_W-1:0]          cnt, cntNext;
  logic                      recValid;
  logic [PC_WIDTH-1:0]       recTarget;
  logic [HIST_WIDTH-1:0]     recHistory;
  logic                      intReq;
  logic [PC_WIDTH-1:0]       intAddr;
  logic                      redirect;

  next_pc_recovery_select #(
    .ISSUE_WIDTH(ISSUE_WIDTH),
    .PC_WIDTH   (PC_WIDTH),
    .HIST_WIDTH (HIST_WIDTH)
  ) uRecSel (
    .brValid   (brValid),
    .brMispred (brMispred),
    .brTarget  (brTarget),
    .brHistory (brHistory),
    .recValid  (recValid),
    .recTarget (recTarget),
    .recHistory(recHistory)
  );

`ifdef NEXT_PC_SEQ_INTERRUPT_EN
  logic                pending;
  logic [PC_WIDTH-1:0] pendingAddr;
  logic                unusedSigs;

  // A same-cycle strobe carries the newest address, so it beats the latched one.
  assign intReq  = (state != INIT) && (pending || interruptAddrWE);
  assign intAddr = interruptAddrWE ? interruptAddrIn : pendingAddr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= 1'b0;
      pendingAddr <= '0;
    end else if (state != INIT) begin
      if (recValid && interruptAddrWE) begin
        pending     <= 1'b1;
        pendingAddr <= interruptAddrIn;
      end else if (!recValid && intReq) begin
        pending <= 1'b0;
      end
    end
  end

  assign unusedSigs = ^pcOut;
`else
  logic unusedSigs;

  assign intReq     = 1'b0;
  assign intAddr    = '0;
  assign unusedSigs = ^{interruptAddrWE, interruptAddrIn, pcOut};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= INIT_LOAD;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext          = state;
    cntNext            = cnt;
    pcWE               = 1'b0;
    pcIn               = '0;
    recoverBrHistory   = 1'b0;
    recoveredBrHistory = '0;
    redirect           = 1'b0;
    case (state)
      INIT: begin
        if (cnt == '0) begin
          pcWE      = 1'b1;
          pcIn      = RESET_VECTOR;
          stateNext = REDIRECT_STATE;
          cntNext   = BUB_LOAD;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      default: begin
        if (recValid) begin
          pcWE               = 1'b1;
          pcIn               = recTarget;
          recoverBrHistory   = 1'b1;
          recoveredBrHistory = recHistory;
          redirect           = 1'b1;
        end else if (intReq) begin
          pcWE     = 1'b1;
          pcIn     = intAddr;
          redirect = 1'b1;
        end else if (!stall) begin
          if (state == RUN) begin
            pcWE = 1'b1;
            pcIn = predNextPC;
          end else if (cnt <= CNT_W'(1)) begin
            stateNext = RUN;
            cntNext   = '0;
          end else begin
            cntNext = cnt - 1'b1;
          end
        end
        if (redirect) begin
          stateNext = REDIRECT_STATE;
          cntNext   = BUB_LOAD;
        end
      end
    endcase
  end

  assign fetchValid = (state == RUN);
  assign initBusy   = (state == INIT);

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Table-driven bench for next_pc_sequencer (INIT_CYCLES=4, REDIRECT_BUBBLES=2); one row per cycle.
module tb_next_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] predNextPC;
  logic [1:0]  brValid;
  logic [1:0]  brMispred;
  logic [63:0] brTarget;
  logic [19:0] brHistory;
  logic        interruptAddrWE;
  logic [31:0] interruptAddrIn;
  logic [31:0] pcOut = '0;
  logic        pcWE;
  logic [31:0] pcIn;
  logic        fetchValid;
  logic        initBusy;
  logic        recoverBrHistory;
  logic [9:0]  recoveredBrHistory;

  next_pc_sequencer #(
    .INIT_CYCLES     (4),
    .REDIRECT_BUBBLES(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .predNextPC        (predNextPC),
    .brValid           (brValid),
    .brMispred         (brMispred),
    .brTarget          (brTarget),
    .brHistory         (brHistory),
    .interruptAddrWE   (interruptAddrWE),
    .interruptAddrIn   (interruptAddrIn),
    .pcOut             (pcOut),
    .pcWE              (pcWE),
    .pcIn              (pcIn),
    .fetchValid        (fetchValid),
    .initBusy          (initBusy),
    .recoverBrHistory  (recoverBrHistory),
    .recoveredBrHistory(recoveredBrHistory)
  );

  always #5 clk = ~clk;

  // PC register the sequencer writes into.
  always @(posedge clk) if (pcWE) pcOut <= pcIn;

  typedef struct {
    string       name;
    logic        st;
    logic [31:0] pred;
    logic [1:0]  v;
    logic [1:0]  m;
    logic [31:0] t0, t1;
    logic [9:0]  h0, h1;
    logic        iwe;
    logic [31:0] ia;
    logic        eWE;
    logic [31:0] ePc;
    logic        eFv;
    logic        eIb;
    logic        eRec;
    logic [9:0]  eH;
    logic        chkPc;
    logic        chkHist;
  } vecT;

  vecT vecs[$];
  vecT expQ[$];
  int  nChecks = 0;
  int  nPass = 0;

  function automatic vecT mk(string n, logic st, logic [31:0] pred, logic [1:0] v, logic [1:0] m,
                             logic [31:0] t0, logic [31:0] t1, logic [9:0] h0, logic [9:0] h1,
                             logic iwe, logic [31:0] ia, logic eWE, logic [31:0] ePc,
                             logic eFv, logic eIb, logic eRec, logic [9:0] eH);
    vecT r;
    r.name = n; r.st = st; r.pred = pred; r.v = v; r.m = m;
    r.t0 = t0; r.t1 = t1; r.h0 = h0; r.h1 = h1; r.iwe = iwe; r.ia = ia;
    r.eWE = eWE; r.ePc = ePc; r.eFv = eFv; r.eIb = eIb; r.eRec = eRec; r.eH = eH;
    r.chkPc = eWE; r.chkHist = eRec;
    return r;
  endfunction

  function automatic vecT rowN(string n, logic st, logic [31:0] pred, logic eWE,
                               logic [31:0] ePc, logic eFv, logic eIb);
    return mk(n, st, pred, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0, eWE, ePc, eFv, eIb, 1'b0, 0);
  endfunction

  // Reset rows also pin pcIn and recoveredBrHistory to zero.
  function automatic vecT rstRow(string n);
    vecT r;
    r = rowN(n, 1'b0, 32'h1004, 1'b0, 32'h0, 1'b0, 1'b1);
    r.chkPc = 1'b1;
    r.chkHist = 1'b1;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else nPass++;
  endtask

  task automatic checkOut();
    vecT e;
    if (expQ.size() == 0) begin
      nChecks++;
      $display("FAIL scoreboard: got empty queue, want one pending row");
      return;
    end
    e = expQ.pop_front();
    cmp({e.name, ".pcWE"}, 32'(pcWE), 32'(e.eWE));
    cmp({e.name, ".fetchValid"}, 32'(fetchValid), 32'(e.eFv));
    cmp({e.name, ".initBusy"}, 32'(initBusy), 32'(e.eIb));
    cmp({e.name, ".recover"}, 32'(recoverBrHistory), 32'(e.eRec));
    if (e.chkPc) cmp({e.name, ".pcIn"}, pcIn, e.ePc);
    if (e.chkHist) cmp({e.name, ".history"}, 32'(recoveredBrHistory), 32'(e.eH));
  endtask

  task automatic applyRow(input vecT r);
    stall = r.st;
    predNextPC = r.pred;
    brValid = r.v;
    brMispred = r.m;
    brTarget = {r.t1, r.t0};
    brHistory = {r.h1, r.h0};
    interruptAddrWE = r.iwe;
    interruptAddrIn = r.ia;
    expQ.push_back(r);
    @(negedge clk);
    checkOut();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    #1;
    applyRow(rstRow("inReset"));
    rst = 1'b1;

    for (int i = 0; i < 3; i++) vecs.push_back(rowN("init", 0, 32'h1004, 0, 0, 0, 1));
    vecs.push_back(rowN("initEnd", 0, 32'h1004, 1, 32'h1000, 0, 1));
    vecs.push_back(rowN("bootBub0", 0, 32'h1004, 0, 0, 0, 0));
    vecs.push_back(rowN("bootBub1", 0, 32'h1004, 0, 0, 0, 0));
    vecs.push_back(rowN("run1004", 0, 32'h1004, 1, 32'h1004, 1, 0));
    vecs.push_back(rowN("run1008", 0, 32'h1008, 1, 32'h1008, 1, 0));
    vecs.push_back(mk("bothMis", 0, 32'h100C, 2'b11, 2'b11, 32'h2000, 32'h3000, 10'h0AA, 10'h155,
                      0, 0, 1, 32'h2000, 1, 0, 1, 10'h0AA));
    vecs.push_back(rowN("misBub0", 0, 32'h2004, 0, 0, 0, 0));
    vecs.push_back(rowN("misBub1", 0, 32'h2008, 0, 0, 0, 0));
    vecs.push_back(rowN("run200C", 0, 32'h200C, 1, 32'h200C, 1, 0));
    vecs.push_back(mk("lane1MisIrq", 0, 32'h2010, 2'b10, 2'b11, 32'h2F00, 32'h3000, 10'h011, 10'h155,
                      1, 32'h8000, 1, 32'h3000, 1, 0, 1, 10'h155));
`ifdef NEXT_PC_SEQ_INTERRUPT_EN
    vecs.push_back(rowN("irqTaken", 0, 32'h3004, 1, 32'h8000, 0, 0));
    vecs.push_back(rowN("irqBub0", 0, 32'h3004, 0, 0, 0, 0));
    vecs.push_back(rowN("irqBub1", 0, 32'h3004, 0, 0, 0, 0));
    vecs.push_back(rowN("run8004", 0, 32'h8004, 1, 32'h8004, 1, 0));
`else
    vecs.push_back(rowN("recBub0", 0, 32'h3004, 0, 0, 0, 0));
    vecs.push_back(rowN("recBub1", 0, 32'h3004, 0, 0, 0, 0));
    vecs.push_back(rowN("run3004", 0, 32'h3004, 1, 32'h3004, 1, 0));
`endif
    vecs.push_back(mk("mis4000", 0, 32'h9999, 2'b01, 2'b01, 32'h4000, 0, 10'h001, 0,
                      0, 0, 1, 32'h4000, 1, 0, 1, 10'h001));
    for (int i = 0; i < 5; i++) vecs.push_back(rowN("bubStall", 1, 32'h4004, 0, 0, 0, 0));
    vecs.push_back(rowN("bubAfterStall", 0, 32'h4004, 0, 0, 0, 0));
    vecs.push_back(mk("misDuringStall", 1, 32'h4004, 2'b01, 2'b01, 32'h5000, 0, 10'h3FF, 0,
                      0, 0, 1, 32'h5000, 0, 0, 1, 10'h3FF));
    vecs.push_back(rowN("restartBub0", 0, 32'h5004, 0, 0, 0, 0));
    vecs.push_back(rowN("restartBub1", 0, 32'h5004, 0, 0, 0, 0));
    vecs.push_back(rowN("run5004", 0, 32'h5004, 1, 32'h5004, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(rowN("runStall", 1, 32'h5008, 0, 0, 1, 0));
`ifdef NEXT_PC_SEQ_INTERRUPT_EN
    vecs.push_back(mk("irqDuringStall", 1, 32'h5008, 0, 0, 0, 0, 0, 0,
                      1, 32'h9000, 1, 32'h9000, 1, 0, 0, 0));
    vecs.push_back(rowN("irqBub0", 0, 32'h9004, 0, 0, 0, 0));
    vecs.push_back(rowN("irqBub1", 0, 32'h9004, 0, 0, 0, 0));
    vecs.push_back(rowN("run9004", 0, 32'h9004, 1, 32'h9004, 1, 0));
    vecs.push_back(mk("misIrqB000", 0, 32'h9008, 2'b01, 2'b01, 32'h7000, 0, 10'h070, 0,
                      1, 32'hB000, 1, 32'h7000, 1, 0, 1, 10'h070));
    vecs.push_back(mk("misIrqC000", 0, 32'h7004, 2'b10, 2'b10, 0, 32'h7100, 0, 10'h071,
                      1, 32'hC000, 1, 32'h7100, 0, 0, 1, 10'h071));
    vecs.push_back(rowN("pendOverwrite", 0, 32'h7104, 1, 32'hC000, 0, 0));
    vecs.push_back(rowN("pendBub0", 0, 32'hC004, 0, 0, 0, 0));
    vecs.push_back(rowN("pendBub1", 0, 32'hC004, 0, 0, 0, 0));
    vecs.push_back(rowN("runC004", 0, 32'hC004, 1, 32'hC004, 1, 0));
`else
    vecs.push_back(mk("irqIgnored", 1, 32'h5008, 0, 0, 0, 0, 0, 0,
                      1, 32'h9000, 0, 0, 1, 0, 0, 0));
    vecs.push_back(rowN("run5008", 0, 32'h5008, 1, 32'h5008, 1, 0));
`endif

    foreach (vecs[i]) applyRow(vecs[i]);

    // Reset during BUBBLE with an interrupt pending: it must not survive into the next boot.
    applyRow(mk("misIrqA000", 0, 32'h600C, 2'b01, 2'b01, 32'h6100, 0, 10'h0F0, 0,
                1, 32'hA000, 1, 32'h6100, 1, 0, 1, 10'h0F0));
    rst = 1'b0;
    applyRow(rstRow("midReset"));
    rst = 1'b1;
    applyRow(mk("initIgnoresBr", 0, 32'h1004, 2'b01, 2'b01, 32'h6000, 0, 10'h00F, 0,
                1, 32'hD000, 0, 0, 0, 1, 0, 0));
    applyRow(rowN("reinit1", 0, 32'h1004, 0, 0, 0, 1));
    applyRow(rowN("reinit2", 0, 32'h1004, 0, 0, 0, 1));
    applyRow(rowN("reinitEnd", 0, 32'h1004, 1, 32'h1000, 0, 1));
    applyRow(rowN("rebootBub0", 0, 32'h1004, 0, 0, 0, 0));
    applyRow(rowN("rebootBub1", 0, 32'h1004, 0, 0, 0, 0));
    applyRow(rowN("rerun1004", 0, 32'h1004, 1, 32'h1004, 1, 0));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
